// File: rtl/interval_timer_pkg.sv
// Shared definitions for the interval timer.
//   state_e        : controller states (IDLE, RUN, DONE)
//   MODE_PERIODIC  : mode value for auto-reloading operation
//   MODE_ONESHOT   : mode value for a single terminal count then DONE
package interval_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/interval_timer.sv
// Programmable interval timer with periodic and one-shot modes.
// The counter runs 0..term_q on enabled cycles, so one period is
// term_q+1 enabled cycles.  Longer intervals are built by cascading
// instances, with tick of one instance driving en of the next.
//
// Ports:
//   clk    in   sole clock, rising edge
//   rst    in   synchronous active-high reset
//   en     in   count qualifier (prescaler tick or constant 1)
//   start  in   load term/mode, clear count, enter RUN (also restarts)
//   stop   in   abort to IDLE; wins over start
//   mode   in   0 = periodic, 1 = one-shot; sampled on start
//   term   in   terminal value; sampled on start
//   tick   out  registered one-cycle pulse at each terminal count
//   count  out  current counter value
//   busy   out  registered, high while in RUN
//   done   out  registered, sticky high in DONE after a one-shot
module interval_timer
  import interval_timer_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int RESET_TERM = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [WIDTH-1:0] term,
  output logic             tick,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] term_q,  term_d;
  logic             mode_q,  mode_d;
  logic             tick_q,  tick_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    term_d  = term_q;
    mode_d  = mode_q;
    tick_d  = 1'b0;

    if (stop) begin
      state_d = IDLE;
      count_d = '0;
    end else if (start) begin
      // Accepted in every state; in RUN this is a restart, and en is
      // ignored on this edge so no tick can fire even at terminal count.
      state_d = RUN;
      count_d = '0;
      term_d  = term;
      mode_d  = mode;
    end else begin
      unique case (state_q)
        RUN: begin
          if (en) begin
            if (count_q == term_q) begin
              count_d = '0;
              tick_d  = 1'b1;
              if (mode_q == MODE_ONESHOT) begin
                state_d = DONE;
              end
            end else begin
              count_d = count_q + 1'b1;
            end
          end
        end
        DONE: begin
          count_d = '0;
        end
        default: begin
          // IDLE: wait for start
        end
      endcase
    end

    // Status flags are registered copies of the next state.
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      term_q  <= WIDTH'(RESET_TERM);
      mode_q  <= MODE_PERIODIC;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      term_q  <= term_d;
      mode_q  <= mode_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tick  = tick_q;
  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_interval_timer.sv
// Self-checking bench for interval_timer: a table of per-cycle vectors
// plus hand-written sequences for long periodic runs, gated enable,
// restart and reset mid-operation.
module tb_interval_timer;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst, en, start, stop, mode;
  logic [WIDTH-1:0] term;
  logic             tick, busy, done;
  logic [WIDTH-1:0] count;

  int checks   = 0;
  int failures = 0;

  interval_timer #(.WIDTH(WIDTH), .RESET_TERM(10)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .start (start),
    .stop  (stop),
    .mode  (mode),
    .term  (term),
    .tick  (tick),
    .count (count),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             rst, start, stop, en, mode;
    logic [WIDTH-1:0] term;
    logic             x_tick;
    logic [WIDTH-1:0] x_count;
    logic             x_busy, x_done;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, s, p, e, m, input int t,
                     input logic xt, input int xc, input logic xb, xd);
    vec_t v;
    v.rst = r; v.start = s; v.stop = p; v.en = e; v.mode = m;
    v.term = WIDTH'(t);
    v.x_tick = xt; v.x_count = WIDTH'(xc); v.x_busy = xb; v.x_done = xd;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%0d expected=%0d", name, idx, act, exp);
    end
  endtask

  // Apply inputs, clock once, sample 1 ns after the edge.
  task automatic step(input logic r, s, p, e, m, input int t);
    rst = r; start = s; stop = p; en = e; mode = m; term = WIDTH'(t);
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int idx,
                           input logic xt, input int xc, input logic xb, xd);
    check({tag, "_tick"},  idx, 32'(tick),  32'(xt));
    check({tag, "_count"}, idx, 32'(count), 32'(xc));
    check({tag, "_busy"},  idx, 32'(busy),  32'(xb));
    check({tag, "_done"},  idx, 32'(done),  32'(xd));
  endtask

  initial begin
    int ticks;
    int exp_c;
    logic exp_t;

    rst = 1'b1; start = 1'b0; stop = 1'b0; en = 1'b0; mode = 1'b0; term = '0;

    //   rst st sp en md term | tick cnt busy done
    add(1, 0, 0, 0, 0, 0,   0, 0, 0, 0);  // reset
    add(1, 1, 1, 1, 0, 0,   0, 0, 0, 0);  // reset overrides controls
    add(0, 0, 0, 1, 0, 0,   0, 0, 0, 0);  // idle ignores en
    add(0, 1, 0, 1, 1, 3,   0, 0, 1, 0);  // one-shot term=3
    add(0, 0, 0, 1, 0, 0,   0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0,   0, 1, 1, 0);  // en=0 holds
    add(0, 0, 0, 1, 0, 9,   0, 2, 1, 0);  // term ignored while running
    add(0, 0, 0, 1, 0, 0,   0, 3, 1, 0);
    add(0, 0, 0, 1, 0, 0,   1, 0, 0, 1);  // terminal -> DONE
    add(0, 0, 0, 1, 0, 0,   0, 0, 0, 1);  // no further ticks
    add(0, 0, 0, 1, 0, 0,   0, 0, 0, 1);
    add(0, 1, 0, 1, 0, 0,   0, 0, 1, 0);  // start from DONE, term=0
    add(0, 0, 0, 1, 0, 0,   1, 0, 1, 0);  // tick every enabled cycle
    add(0, 0, 0, 1, 0, 0,   1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 1, 0);
    add(0, 0, 0, 1, 0, 0,   1, 0, 1, 0);
    add(0, 1, 1, 1, 0, 5,   0, 0, 0, 0);  // start+stop -> stop
    add(0, 0, 0, 1, 0, 0,   0, 0, 0, 0);
    add(0, 1, 0, 1, 1, 2,   0, 0, 1, 0);  // one-shot term=2
    add(0, 0, 0, 1, 0, 0,   0, 1, 1, 0);
    add(0, 0, 0, 1, 0, 0,   0, 2, 1, 0);
    add(0, 1, 0, 1, 0, 2,   0, 0, 1, 0);  // restart at count==term: no tick
    add(0, 0, 0, 1, 0, 0,   0, 1, 1, 0);
    add(0, 0, 0, 1, 0, 0,   0, 2, 1, 0);
    add(0, 0, 0, 1, 0, 0,   1, 0, 1, 0);  // now periodic: stays in RUN
    add(0, 0, 0, 1, 0, 0,   0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0,   0, 1, 1, 0);
    add(0, 0, 1, 1, 0, 0,   0, 0, 0, 0);  // stop mid-run
    add(0, 1, 0, 1, 1, 1,   0, 0, 1, 0);  // one-shot term=1
    add(0, 0, 0, 1, 0, 0,   0, 1, 1, 0);
    add(0, 0, 0, 1, 0, 0,   1, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0,   0, 0, 0, 0);  // stop clears done

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].start, vecs[i].stop, vecs[i].en,
           vecs[i].mode, int'(vecs[i].term));
      check_all("vec", i, vecs[i].x_tick, int'(vecs[i].x_count),
                vecs[i].x_busy, vecs[i].x_done);
      $display("vec %0d: tick=%0d count=%0d busy=%0d done=%0d",
               i, tick, count, busy, done);
    end

    // Periodic term=10, constant en: count 0..10, tick every 11 cycles.
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 10);
    check_all("per_start", 0, 1'b0, 0, 1'b1, 1'b0);
    exp_c = 0;
    ticks = 0;
    for (int k = 1; k <= 33; k++) begin
      step(0, 0, 0, 1, 0, 0);
      exp_t = (exp_c == 10);
      exp_c = (exp_c == 10) ? 0 : exp_c + 1;
      if (tick) ticks++;
      check_all("periodic", k, exp_t, exp_c, 1'b1, 1'b0);
    end
    check("periodic_ticks", 33, 32'(ticks), 32'd3);
    $display("periodic term=10: %0d ticks in 33 cycles", ticks);

    // Gated en, term=2: en 1,0,1,0... ticks every 6 clocks.
    step(0, 1, 0, 0, 0, 2);
    for (int k = 1; k <= 24; k++) begin
      step(0, 0, 0, (k % 2 == 1), 0, 0);
      exp_c = ((k + 1) / 2) % 3;
      exp_t = (k % 2 == 1) && (exp_c == 0);
      check_all("gated", k, exp_t, exp_c, 1'b1, 1'b0);
    end
    $display("gated en term=2: done");

    // Restart mid-run with term=5 -> period of 6.
    step(0, 1, 0, 1, 0, 10);
    for (int k = 1; k <= 4; k++) step(0, 0, 0, 1, 0, 0);
    check_all("pre_restart", 4, 1'b0, 4, 1'b1, 1'b0);
    step(0, 1, 0, 1, 0, 5);
    check_all("restart", 0, 1'b0, 0, 1'b1, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      step(0, 0, 0, 1, 0, 0);
      check_all("restart_run", k, (k % 6 == 0), k % 6, 1'b1, 1'b0);
    end
    $display("restart term=5: done");

    // Reset at count=term_q-1, then resume with term=10.
    step(0, 1, 0, 1, 0, 10);
    for (int k = 1; k <= 9; k++) step(0, 0, 0, 1, 0, 0);
    check_all("pre_reset", 9, 1'b0, 9, 1'b1, 1'b0);
    step(1, 0, 0, 1, 0, 0);
    check_all("mid_reset", 0, 1'b0, 0, 1'b0, 1'b0);
    step(0, 0, 0, 1, 0, 0);
    check_all("post_reset_idle", 0, 1'b0, 0, 1'b0, 1'b0);
    step(0, 1, 0, 1, 0, 10);
    for (int k = 1; k <= 11; k++) begin
      step(0, 0, 0, 1, 0, 0);
      check_all("resume", k, (k == 11), k % 11, 1'b1, 1'b0);
    end
    $display("reset mid-run and resume: done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/interval_timer.md
INTERVAL_TIMER -- requirements
Module: interval_timer

Interface
REQ-001 Parameter WIDTH, default 16: width of the counter, the term input and the count output.
REQ-002 Parameter RESET_TERM, default 10: terminal value loaded into term_q at reset.
REQ-003 clk  input  1  sole clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  count qualifier (upstream prescaler tick or constant 1).
REQ-006 start  input  1  single-cycle request: load term, clear count, enter RUN.
REQ-007 stop  input  1  single-cycle request: abort and return to IDLE.
REQ-008 mode  input  1  0 = periodic, 1 = one-shot; sampled with term on start.
REQ-009 term  input  WIDTH  terminal value; sampled only on an accepted start.
REQ-010 tick  output  1  registered one-cycle pulse at each terminal count.
REQ-011 count  output  WIDTH  current counter value.
REQ-012 busy  output  1  high while state is RUN.
REQ-013 done  output  1  sticky; high in DONE state after a one-shot completes.

Function
REQ-014 The block SHALL implement states IDLE, RUN and DONE.
REQ-015 In IDLE with start=1 and stop=0, the block SHALL latch term_q<=term and mode_q<=mode, set count<=0 and enter RUN.
REQ-016 In RUN with en=1 and count!=term_q, the block SHALL set count<=count+1 and tick<=0.
REQ-017 In RUN with en=1 and count==term_q, the block SHALL set count<=0 and tick<=1 for exactly one cycle.
REQ-018 Period SHALL be term_q+1 enabled cycles; term_q=0 SHALL give tick on every enabled cycle.
REQ-019 In RUN with en=0, the block SHALL hold count and drive tick<=0.
REQ-020 On terminal count with mode_q=0, the block SHALL stay in RUN; with mode_q=1, it SHALL go to DONE.
REQ-021 In DONE, count SHALL hold 0 and done SHALL be 1; start SHALL behave as in IDLE (REQ-015) and clear done.
REQ-022 start in RUN SHALL restart: resample term/mode, count<=0, no tick that cycle even if count==term_q.
REQ-023 On the start edge, en SHALL be ignored; counting SHALL begin on the next enabled cycle.
REQ-024 stop=1 in any state SHALL give state<=IDLE, count<=0, tick<=0, done<=0.
REQ-025 stop and start asserted together SHALL resolve as stop.
REQ-026 Counter arithmetic SHALL be unsigned WIDTH-bit; count SHALL never exceed term_q.
REQ-027 busy SHALL equal (state==RUN), and done SHALL equal (state==DONE), both registered.

Reset
REQ-028 While rst=1 at a clock edge: state<=IDLE, count<=0, tick<=0, busy<=0, done<=0, term_q<=RESET_TERM, mode_q<=0.
REQ-029 rst SHALL override start, stop and en; a reset mid-RUN SHALL suppress any pending tick.
REQ-030 The first edge with rst=0 SHALL process inputs normally.

Structure
REQ-031 A shared package SHALL hold the state enumeration (IDLE, RUN, DONE) and the mode constants MODE_PERIODIC=0 and MODE_ONESHOT=1.
REQ-032 The block SHALL be a single module with no sub-module.
REQ-033 Longer intervals SHALL be built by cascading instances, with tick of one instance driving en of the next.

Verification
REQ-034 Periodic, constant en: rst, then start with term=10, mode=0, en=1 -> tick every 11 cycles, count sequence 0..10, busy=1, done=0.
REQ-035 One-shot: start with term=3, mode=1, en=1 -> one tick 4 enabled cycles after start, then done=1, busy=0, count=0, no further ticks.
REQ-036 Gated en: term=2, en toggling 1,0,1,0,... -> tick every 6 clocks, and count holds during en=0.
REQ-037 Boundary term=0, mode=0, en=1 -> tick high every cycle after the start edge.
REQ-038 Restart and abort: mid-RUN start with term=5 -> count=0 and new period of 6; start+stop together -> IDLE, count=0, no tick.
REQ-039 Reset mid-operation: rst at count=term_q-1 -> next cycle IDLE, tick=0, term_q=10; a start with term=10 then resumes normally.
